// File: rtl/nn_isa_pkg.sv
// Shared ISA definitions for the fetch unit and control unit: opcodes,
// instruction field widths, fetch FSM encoding and the fetch queue entry.
package nn_isa_pkg;

    localparam int OPC_W  = 4;
    localparam int REG_W  = 4;
    localparam int PC_W   = 8;
    localparam int WORD_W = 16;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_MUL  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_SINN = 4'h3;
    localparam logic [OPC_W-1:0] OPC_MAC  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_ADDI = 4'h9;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hB;
    localparam logic [OPC_W-1:0] OPC_LD   = 4'hE;
    localparam logic [OPC_W-1:0] OPC_ST   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_t;

    // raw_opcode keeps the fetched encoding so HALT is recognised at pop time;
    // opcode is the sanitised value presented downstream.
    typedef struct packed {
        logic [OPC_W-1:0] raw_opcode;
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd_imm;
        logic [PC_W-1:0]  pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic opcode_legal(input logic [OPC_W-1:0] op);
        case (op)
            OPC_NOP, OPC_ADD, OPC_MUL, OPC_SINN, OPC_MAC,
            OPC_ADDI, OPC_HALT, OPC_LD, OPC_ST: opcode_legal = 1'b1;
            default:                            opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Two-entry FIFO holding fetched instructions between memory and issue.
module instr_fifo #(
    parameter int DATA_W = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    logic [1:0][DATA_W-1:0] mem_q, mem_d;
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;
    logic                   do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: reads words from instruction memory, queues them with
// their pc, and issues them in order until a HALT drains out of the queue.
module instr_fetch_unit
    import nn_isa_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  start_pc,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [3:0]  opcode,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [3:0]  rd_imm,
    output logic [7:0]  issue_pc,
    output logic        halted,
    output logic        illegal_err
);

    fetch_state_t   state_q, state_d;
    logic [7:0]     pc_q, pc_d;
    logic           outst_q, outst_d;
    logic           halted_q, halted_d;
    logic           illegal_q, illegal_d;

    logic           fifo_full, fifo_empty;
    logic           transfer, pop;
    logic           word_legal;
    fetch_entry_t   push_entry, head;

    // Request only drops on ack: the FIFO can only fill through a push.
    assign imem_req    = (state_q == ST_FETCH) && (outst_q || !fifo_full);
    assign imem_addr   = pc_q;
    assign transfer    = imem_req && imem_ack;
    assign issue_valid = !fifo_empty;
    assign pop         = issue_valid && issue_ready;
    assign word_legal  = opcode_legal(imem_rdata[15:12]);

    always_comb begin
        push_entry.raw_opcode = imem_rdata[15:12];
        push_entry.opcode     = word_legal ? imem_rdata[15:12] : OPC_NOP;
        push_entry.rs         = imem_rdata[11:8];
        push_entry.rt         = imem_rdata[7:4];
        push_entry.rd_imm     = imem_rdata[3:0];
        push_entry.pc         = pc_q;
    end

    instr_fifo #(.DATA_W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (transfer),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign opcode      = head.opcode;
    assign rs          = head.rs;
    assign rt          = head.rt;
    assign rd_imm      = head.rd_imm;
    assign issue_pc    = head.pc;
    assign halted      = halted_q;
    assign illegal_err = illegal_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        outst_d   = 1'b0;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                outst_d = imem_req && !imem_ack;
                if (transfer) begin
                    pc_d = pc_q + 8'd1;
                    if (!word_legal) illegal_d = 1'b1;
                    if (imem_rdata[15:12] == OPC_HALT) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head.raw_opcode == OPC_HALT) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end
            ST_HALTED: begin
                if (start) begin
                    halted_d = 1'b0;
                    pc_d     = start_pc;
                    state_d  = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= 8'd0;
            outst_q   <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            outst_q   <= outst_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a program-level model predicts the
// issue stream and request addresses; monitor and memory responder check them.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = 8'd0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'd0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [3:0]  opcode, rs, rt, rd_imm;
    logic [7:0]  issue_pc;
    logic        halted, illegal_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic [23:0] exp_q [$];
    logic [7:0]  addr_q [$];
    logic        exp_illegal = 1'b0;

    int          lat_mode = 1;
    int          lat_idx = 0;
    bit          manual = 1'b0;
    logic        man_ack = 1'b0;
    logic [15:0] man_data = 16'd0;
    bit          rdy_hold = 1'b1;
    logic        rdy_val = 1'b1;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_pc    (start_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd_imm      (rd_imm),
        .issue_pc    (issue_pc),
        .halted      (halted),
        .illegal_err (illegal_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hB, 4'hE, 4'hF};
    endfunction

    // Program-level model: walk memory from spc until HALT.
    task automatic model_start(input logic [7:0] spc);
        logic [7:0]  pc;
        logic [15:0] w;
        pc = spc;
        for (int k = 0; k < 256; k++) begin
            w = mem[pc];
            addr_q.push_back(pc);
            exp_q.push_back({legal(w[15:12]) ? w[15:12] : 4'h0, w[11:0], pc});
            if (!legal(w[15:12])) exp_illegal = 1'b1;
            if (w[15:12] == 4'hB) break;
            pc = pc + 8'd1;
        end
    endtask

    task automatic rand_prog(input logic [7:0] spc, input int len);
        logic [7:0]  a;
        logic [15:0] w;
        a = spc;
        for (int k = 0; k < len; k++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hB) w[15:12] = 4'h1;
            mem[a] = w;
            a = a + 8'd1;
        end
        mem[a] = {4'hB, 12'($urandom)};
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [7:0] pc);
        start    = 1'b1;
        start_pc = pc;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n;
        n = 0;
        while (!halted && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_halted"}, 32'(halted), 32'd1);
        tick(2);
        check({name, "_req_idle"}, 32'(imem_req), 32'd0);
        check({name, "_valid_idle"}, 32'(issue_valid), 32'd0);
        check({name, "_issue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_addr_left"}, 32'(addr_q.size()), 32'd0);
        check({name, "_illegal"}, 32'(illegal_err), 32'(exp_illegal));
    endtask

    // Memory responder: acks after a chosen latency, checks address order/stability.
    initial begin : responder
        bit         busy;
        int         wait_cnt;
        logic [7:0] held;
        busy = 1'b0;
        wait_cnt = 0;
        held = 8'd0;
        forever begin
            @(posedge clk);
            #2;
            if (manual) begin
                imem_ack   = man_ack;
                imem_rdata = man_data;
                busy       = 1'b0;
            end else begin
                imem_ack = 1'b0;
                if (reset) begin
                    busy = 1'b0;
                end else if (imem_req) begin
                    if (!busy) begin
                        busy = 1'b1;
                        held = imem_addr;
                        case (lat_mode)
                            0:       wait_cnt = $urandom_range(0, 3);
                            1:       wait_cnt = 1;
                            default: begin
                                wait_cnt = (lat_idx % 3 == 0) ? 0 : (lat_idx % 3 == 1) ? 3 : 7;
                                lat_idx++;
                            end
                        endcase
                    end else begin
                        check("addr_stable", 32'(imem_addr), 32'(held));
                    end
                    if (wait_cnt == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem[imem_addr];
                        busy       = 1'b0;
                        if (addr_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL req_extra: got request to 0x%0h expected none", imem_addr);
                        end else begin
                            check("req_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
                        end
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            issue_ready = rdy_hold ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset && issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_extra: got issue at pc 0x%0h expected none", issue_pc);
                end else begin
                    check("issue", 32'({opcode, rs, rt, rd_imm, issue_pc}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : main
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        tick(2);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_valid", 32'(issue_valid), 32'd0);
        check("rst_fields", 32'({opcode, rs, rt, rd_imm, issue_pc}), 32'd0);
        check("rst_flags", 32'({halted, illegal_err}), 32'd0);
        reset = 1'b0;
        tick(2);
        check("idle_no_req", 32'(imem_req), 32'd0);

        // Straight line program
        mem[8'h10] = 16'h1123;
        mem[8'h11] = 16'h2456;
        mem[8'h12] = 16'hB000;
        lat_mode = 1;
        model_start(8'h10);
        do_start(8'h10);
        run_to_halt("straight");

        // Address wrap, restart from HALTED
        mem[8'hFF] = 16'h0000;
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'hB000;
        model_start(8'hFF);
        do_start(8'hFF);
        run_to_halt("wrap");

        // Undefined opcode
        mem[8'h20] = 16'h5123;
        mem[8'h21] = 16'hB000;
        model_start(8'h20);
        do_start(8'h20);
        run_to_halt("illegal");

        // Backpressure, plus a start that must be ignored while fetching
        rand_prog(8'h40, 5);
        rdy_val = 1'b0;
        model_start(8'h40);
        do_start(8'h40);
        tick(10);
        check("bp_valid", 32'(issue_valid), 32'd1);
        check("bp_req", 32'(imem_req), 32'd0);
        check("bp_pc", 32'(imem_addr), 32'h42);
        check("bp_head", 32'(issue_pc), 32'h40);
        do_start(8'h99);
        tick(2);
        check("bp_start_ignored", 32'({imem_req, imem_addr}), 32'h042);
        rdy_val = 1'b1;
        run_to_halt("backpressure");

        // Variable ack latency 0,3,7 with random ready
        lat_mode = 2;
        lat_idx  = 0;
        rdy_hold = 1'b0;
        rand_prog(8'h80, 6);
        model_start(8'h80);
        do_start(8'h80);
        run_to_halt("latency");

        // Random programs
        lat_mode = 0;
        for (int r = 0; r < 6; r++) begin
            logic [7:0] spc;
            spc = 8'($urandom);
            rand_prog(spc, $urandom_range(1, 10));
            model_start(spc);
            do_start(spc);
            run_to_halt("random");
        end

        // Single-cycle latency, then reset with a request pending
        rdy_hold = 1'b1;
        rdy_val  = 1'b1;
        manual   = 1'b1;
        man_ack  = 1'b0;
        do_start(8'h70);
        check("man_req", 32'({imem_req, imem_addr}), 32'h170);
        man_ack  = 1'b1;
        man_data = 16'h1ABC;
        exp_q.push_back(24'h1ABC70);
        tick();
        man_ack = 1'b0;
        check("latency_valid", 32'(issue_valid), 32'd1);
        check("latency_head", 32'({opcode, rs, rt, rd_imm, issue_pc}), 32'h1ABC70);
        check("next_req", 32'({imem_req, imem_addr}), 32'h171);
        tick(2);
        reset = 1'b1;
        exp_q.delete();
        addr_q.delete();
        exp_illegal = 1'b0;
        tick();
        reset    = 1'b0;
        man_ack  = 1'b1;
        man_data = 16'hB000;
        tick();
        man_ack = 1'b0;
        tick(2);
        check("post_rst_req", 32'({imem_req, imem_addr}), 32'd0);
        check("post_rst_valid", 32'(issue_valid), 32'd0);
        check("post_rst_fields", 32'({opcode, rs, rt, rd_imm, issue_pc}), 32'd0);
        check("post_rst_flags", 32'({halted, illegal_err}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL provide: reset  in  1  asynchronous, active-high.
REQ-003 SHALL provide: start  in  1  one-cycle pulse; begins fetching at start_pc.
REQ-004 SHALL provide: start_pc  in  8  word address of first instruction.
REQ-005 SHALL provide: imem_req  out  1  instruction-memory read request.
REQ-006 SHALL provide: imem_addr  out  8  word address; stable while imem_req high.
REQ-007 SHALL provide: imem_ack  in  1  read complete; imem_rdata valid this cycle.
REQ-008 SHALL provide: imem_rdata  in  16  instruction word [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd/imm.
REQ-009 SHALL provide: issue_valid  out  1  head instruction presented to control unit.
REQ-010 SHALL provide: issue_ready  in  1  downstream accepts head this cycle.
REQ-011 SHALL provide: opcode  out  4; rs, rt, rd_imm  out  4 each; issue_pc  out  8.
REQ-012 SHALL provide: halted  out  1  HALT issued, fetch stopped.
REQ-013 SHALL provide: illegal_err  out  1  sticky; undefined opcode fetched.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, DRAIN, HALTED.
REQ-015 IDLE: start -> pc=start_pc, FETCH; imem_ack ignored.
REQ-016 FETCH: imem_req=1 iff FIFO has a free slot and no request outstanding; at most one outstanding request.
REQ-017 Handshake: transfer on cycle imem_req&imem_ack; ack may arrive same cycle as req or any later cycle; imem_req held until ack.
REQ-018 On transfer: word plus pc pushed to 2-entry FIFO; pc increments by 1, wrapping 255->0.
REQ-019 Latency: word acked in cycle N presented with issue_valid=1 in cycle N+1 (FIFO was empty).
REQ-020 Pop on issue_valid&issue_ready; FIFO order preserved; simultaneous push and pop at count 1 keeps count 1.
REQ-021 issue_valid=0 when FIFO empty; outputs opcode/rs/rt/rd_imm/issue_pc hold last head value, don't-care.
REQ-022 Legal opcodes: 0000 NOP, 0001 ADD, 0010 MUL, 0011 SINN, 0100 MAC, 1001 ADDI, 1011 HALT, 1110 LD, 1111 ST.
REQ-023 Undefined opcode on transfer: stored as 0000 (NOP), fields kept, illegal_err set and held until reset.
REQ-024 HALT word transferred: no further requests; state -> DRAIN.
REQ-025 DRAIN: FIFO continues issuing; when HALT entry is popped -> HALTED, halted=1 next cycle.
REQ-026 HALTED: imem_req=0, issue_valid=0; start -> clear halted, pc=start_pc, FETCH; illegal_err unaffected.
REQ-027 start outside IDLE/HALTED SHALL be ignored.
REQ-028 issue_ready held low: FIFO fills to 2, imem_req deasserts, pc frozen until a pop.

Reset
REQ-029 Reset SHALL force: state IDLE, pc=0, FIFO empty, outstanding flag 0, imem_req=0, imem_addr=0, issue_valid=0, opcode/rs/rt/rd_imm=0, issue_pc=0, halted=0, illegal_err=0.
REQ-030 Reset mid-transfer SHALL discard the outstanding request; late imem_ack after reset ignored (IDLE).

Structure
REQ-031 Opcode constants, instruction field widths and state encoding SHALL live in shared package nn_isa_pkg, also used by the control unit.
REQ-032 The 2-entry FIFO SHALL be sub-module instr_fifo (push, pop, full, empty, 28-bit data).

Verification
REQ-033 Straight line: start_pc=0x10, mem ADD,MUL,HALT, ack 1-cycle, ready=1 -> issues ADD@0x10, MUL@0x11, HALT@0x12; halted=1; no request to 0x13.
REQ-034 Backpressure: ready=0 for 10 cycles -> FIFO holds 2, imem_req=0, pc=start_pc+2; ready=1 -> issue order intact.
REQ-035 Wrap: start_pc=0xFF, words NOP,NOP,HALT -> imem_addr sequence 0xFF,0x00,0x01.
REQ-036 Illegal: word 0x5123 -> issued opcode 0000, rs=1, rt=2, rd_imm=3, illegal_err=1 persists through HALT and restart.
REQ-037 Variable latency: ack delays 0,3,7 cycles -> imem_addr stable while req high, one outstanding, correct order.
REQ-038 Reset asserted while req pending, ack arrives 1 cycle after release -> no push, state IDLE, all outputs at reset values.
